// File: rtl/pie_cmd_gen_if.sv
// Command/timing inputs and waveform/status outputs of the PIE command generator.
// The slave modport is the generator side; the master modport is the driver side.
interface pie_cmd_gen_if #(
    parameter int MAXBITS = 64,
    parameter int CNTW    = 16,
    parameter int LENW    = 7
);
    logic               start;
    logic               abort;
    logic [MAXBITS-1:0] cmd_bits;
    logic [LENW-1:0]    cmd_len;
    logic               preamble_en;
    logic [CNTW-1:0]    delim_ticks;
    logic [CNTW-1:0]    pw_ticks;
    logic [CNTW-1:0]    tari_ticks;
    logic [CNTW-1:0]    data1_ticks;
    logic [CNTW-1:0]    rtcal_ticks;
    logic [CNTW-1:0]    trcal_ticks;
    logic               demod_out;
    logic               ready;
    logic               busy;
    logic               done;
    logic               err;
    logic               bit_strobe;

    modport master (
        output start, abort, cmd_bits, cmd_len, preamble_en,
               delim_ticks, pw_ticks, tari_ticks, data1_ticks, rtcal_ticks, trcal_ticks,
        input  demod_out, ready, busy, done, err, bit_strobe
    );

    modport slave (
        input  start, abort, cmd_bits, cmd_len, preamble_en,
               delim_ticks, pw_ticks, tari_ticks, data1_ticks, rtcal_ticks, trcal_ticks,
        output demod_out, ready, busy, done, err, bit_strobe
    );
endinterface

// File: rtl/pie_cmd_gen.sv
// Reader-side PIE command generator: delimiter, data-0, RTcal, optional TRcal,
// then MSB-first payload symbols, each symbol ending in a pw_ticks low pulse.
module pie_cmd_gen #(
    parameter int MAXBITS = 64,
    parameter int CNTW    = 16,
    parameter int LENW    = 7
) (
    input logic          clk,
    input logic          reset,
    pie_cmd_gen_if.slave bus
);
    localparam int IDXW = (MAXBITS > 1) ? $clog2(MAXBITS) : 1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DELIM  = 4'd1,
        D0_HI  = 4'd2,
        D0_LO  = 4'd3,
        RT_HI  = 4'd4,
        RT_LO  = 4'd5,
        TR_HI  = 4'd6,
        TR_LO  = 4'd7,
        BIT_HI = 4'd8,
        BIT_LO = 4'd9,
        FIN    = 4'd10
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNTW-1:0]    cnt_r, cnt_nxt_s;
    logic [IDXW-1:0]    idx_r, idx_nxt_s;
    logic [MAXBITS-1:0] bits_r;
    logic [CNTW-1:0]    pw_r, tari_r, data1_r, rtcal_r, trcal_r;
    logic               pre_r;
    logic               accept_s, enter_bit_s, last_s, sym_bit_s;
    logic               err_nxt_s, strobe_nxt_s;
    logic               demod_r, ready_r, busy_r, done_r, err_r, strobe_r;

    function automatic logic cfg_valid(
        input logic [CNTW-1:0] delim, pw, tari, data1, rtcal, trcal,
        input logic            pre,
        input logic [LENW-1:0] len
    );
        cfg_valid = (pw >= CNTW'(1)) && (pw < tari) && (tari < data1) &&
                    (rtcal > pw) && (!pre || (trcal > pw)) &&
                    (delim >= CNTW'(1)) &&
                    (len >= LENW'(1)) && (len <= LENW'(MAXBITS));
    endfunction

    // Validity guarantees sym > pw, so the high part never underflows.
    function automatic logic [CNTW-1:0] hi_len(input logic [CNTW-1:0] sym, pw);
        hi_len = sym - pw;
    endfunction

    assign last_s = (cnt_r == CNTW'(1));

    // Next-state, phase counter reload and bit index sequencing.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r - CNTW'(1);
        idx_nxt_s    = idx_r;
        accept_s     = 1'b0;
        enter_bit_s  = 1'b0;
        err_nxt_s    = 1'b0;
        strobe_nxt_s = 1'b0;
        if ((state_r != IDLE) && (state_r != FIN) && bus.abort) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = cnt_r;
        end else begin
            case (state_r)
                IDLE, FIN: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                    if (bus.start && !bus.abort) begin
                        if (cfg_valid(bus.delim_ticks, bus.pw_ticks, bus.tari_ticks,
                                      bus.data1_ticks, bus.rtcal_ticks, bus.trcal_ticks,
                                      bus.preamble_en, bus.cmd_len)) begin
                            accept_s    = 1'b1;
                            state_nxt_s = DELIM;
                            cnt_nxt_s   = bus.delim_ticks;
                            idx_nxt_s   = IDXW'(bus.cmd_len - LENW'(1));
                        end else begin
                            err_nxt_s = 1'b1;
                        end
                    end else begin
                        err_nxt_s = 1'b0;
                    end
                end
                DELIM:  if (last_s) begin state_nxt_s = D0_HI;  cnt_nxt_s = hi_len(tari_r, pw_r);  end else begin state_nxt_s = DELIM;  end
                D0_HI:  if (last_s) begin state_nxt_s = D0_LO;  cnt_nxt_s = pw_r;                  end else begin state_nxt_s = D0_HI;  end
                D0_LO:  if (last_s) begin state_nxt_s = RT_HI;  cnt_nxt_s = hi_len(rtcal_r, pw_r); end else begin state_nxt_s = D0_LO;  end
                RT_HI:  if (last_s) begin state_nxt_s = RT_LO;  cnt_nxt_s = pw_r;                  end else begin state_nxt_s = RT_HI;  end
                TR_HI:  if (last_s) begin state_nxt_s = TR_LO;  cnt_nxt_s = pw_r;                  end else begin state_nxt_s = TR_HI;  end
                BIT_HI: if (last_s) begin state_nxt_s = BIT_LO; cnt_nxt_s = pw_r;                  end else begin state_nxt_s = BIT_HI; end
                RT_LO: begin
                    if (last_s && pre_r) begin
                        state_nxt_s = TR_HI;
                        cnt_nxt_s   = hi_len(trcal_r, pw_r);
                    end else if (last_s) begin
                        enter_bit_s = 1'b1;
                    end else begin
                        state_nxt_s = RT_LO;
                    end
                end
                TR_LO: if (last_s) begin enter_bit_s = 1'b1; end else begin state_nxt_s = TR_LO; end
                BIT_LO: begin
                    if (last_s && (idx_r == IDXW'(0))) begin
                        state_nxt_s = FIN;
                    end else if (last_s) begin
                        idx_nxt_s   = idx_r - IDXW'(1);
                        enter_bit_s = 1'b1;
                    end else begin
                        state_nxt_s = BIT_LO;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
        sym_bit_s = bits_r[idx_nxt_s];
        if (enter_bit_s) begin
            state_nxt_s  = BIT_HI;
            cnt_nxt_s    = hi_len(sym_bit_s ? data1_r : tari_r, pw_r);
            strobe_nxt_s = 1'b1;
        end else begin
            strobe_nxt_s = 1'b0;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNTW'(0);
            idx_r    <= IDXW'(0);
            demod_r  <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            demod_r  <= !((state_nxt_s == DELIM) || (state_nxt_s == D0_LO) || (state_nxt_s == RT_LO) ||
                          (state_nxt_s == TR_LO) || (state_nxt_s == BIT_LO));
            ready_r  <= (state_nxt_s == IDLE) || (state_nxt_s == FIN);
            busy_r   <= (state_nxt_s != IDLE) && (state_nxt_s != FIN);
            done_r   <= (state_nxt_s == FIN);
            err_r    <= err_nxt_s;
            strobe_r <= strobe_nxt_s;
        end
    end

    // Frame configuration captured on the accepting edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bits_r  <= {MAXBITS{1'b0}};
            pw_r    <= CNTW'(0);
            tari_r  <= CNTW'(0);
            data1_r <= CNTW'(0);
            rtcal_r <= CNTW'(0);
            trcal_r <= CNTW'(0);
            pre_r   <= 1'b0;
        end else if (accept_s) begin
            bits_r  <= bus.cmd_bits;
            pw_r    <= bus.pw_ticks;
            tari_r  <= bus.tari_ticks;
            data1_r <= bus.data1_ticks;
            rtcal_r <= bus.rtcal_ticks;
            trcal_r <= bus.trcal_ticks;
            pre_r   <= bus.preamble_en;
        end
    end

    assign bus.demod_out  = demod_r;
    assign bus.ready      = ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.bit_strobe = strobe_r;
endmodule
